// File: rtl/sincos_arb_pkg.sv
// Shared types for the sine/cosine LUT arbiter: float width helper, tag struct, FSM states.
// Tag index is sized for the largest supported requester count (8).
package sincos_arb_pkg;

    localparam int EXP_LEN_DEF      = 8;
    localparam int MANTISSA_LEN_DEF = 23;

    function automatic int float_width(input int exp_len, input int mantissa_len);
        return exp_len + mantissa_len + 1;
    endfunction

    localparam int W_DEF = float_width(EXP_LEN_DEF, MANTISSA_LEN_DEF);

    localparam int IDX_W = 3;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sincos_lut_arbiter_rr_grant.sv
// Combinational picker: first asserted request at or after ptr_i (mod N) wins.
// Zero latency; no backpressure, pure function of its inputs.
module rr_grant
    import sincos_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = IW'(j);
                gnt_o[j] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/sincos_lut_arbiter.sv
// Shares one sine_calculator pipeline among N_REQ requesters; tags track in-flight ops and steer results back.
// Grant is same-cycle, result returns CALC_LATENCY cycles later; hold stalls grants. SINCOS_ARB_FIXED_PRIO_EN selects fixed priority.
module sincos_lut_arbiter
    import sincos_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int CALC_LATENCY = 2,
    localparam int W           = float_width(EXP_LEN, MANTISSA_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][W-1:0]   req_theta,
    input  logic [N_REQ-1:0]          req_sine_cosine,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [W-1:0]              rsp_value,
    input  logic                      hold,
    output logic                      idle,
    output logic                      calc_enable,
    output logic [W-1:0]              calc_theta,
    output logic                      calc_sine_cosine,
    input  logic [W-1:0]              calc_value
);

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    ptr_cur;
    logic             win_any;
    logic             grant;
    logic             pipe_empty;
    state_t           state_q, state_d;
    tag_t             tag_q [CALC_LATENCY];
    tag_t             last_tag;

`ifdef SINCOS_ARB_FIXED_PRIO_EN
    assign ptr_cur = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_cur = ptr_q;
`endif

    rr_grant #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_cur),
        .gnt_o (win_onehot),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // DRAIN with hold released resumes granting immediately, so only rst/hold gate grants.
    assign grant            = !rst && !hold && win_any;
    assign req_ready        = grant ? win_onehot : '0;
    assign calc_enable      = grant;
    assign calc_theta       = grant ? req_theta[win_idx] : '0;
    assign calc_sine_cosine = grant ? req_sine_cosine[win_idx] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CALC_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{vld: grant, idx: IDX_W'(win_idx)};
            for (int i = 1; i < CALC_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < CALC_LATENCY; i++) begin
            if (tag_q[i].vld) pipe_empty = 1'b0;
        end
    end

    assign last_tag = tag_q[CALC_LATENCY-1];

    always_comb begin
        rsp_valid = '0;
        rsp_value = '0;
        if (!rst && last_tag.vld) begin
            rsp_valid[last_tag.idx[IW-1:0]] = 1'b1;
            rsp_value                       = calc_value;
        end
    end

    assign idle = rst || (pipe_empty && !grant);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) state_d = BUSY;
            end
            BUSY: begin
                if (hold)                     state_d = pipe_empty ? IDLE : DRAIN;
                else if (pipe_empty && !grant) state_d = IDLE;
            end
            DRAIN: begin
                if (!hold)          state_d = BUSY;
                else if (pipe_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_sincos_lut_arbiter.sv
// Scoreboard bench for sincos_lut_arbiter with a behavioural 2-cycle calculator model.
module tb_sincos_lut_arbiter;
    import sincos_arb_pkg::*;

    localparam int N = 4;
    localparam int L = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N-1:0][31:0] req_theta;
    logic [N-1:0]       req_sine_cosine;
    logic [N-1:0]       rsp_valid;
    logic [31:0]        rsp_value;
    logic               hold;
    logic               idle;
    logic               calc_enable;
    logic [31:0]        calc_theta;
    logic               calc_sine_cosine;
    logic [31:0]        calc_value;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          idx;
        logic [31:0] value;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sincos_lut_arbiter #(
        .N_REQ(N), .EXP_LEN(8), .MANTISSA_LEN(23), .CALC_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_theta(req_theta), .req_sine_cosine(req_sine_cosine),
        .rsp_valid(rsp_valid), .rsp_value(rsp_value),
        .hold(hold), .idle(idle),
        .calc_enable(calc_enable), .calc_theta(calc_theta),
        .calc_sine_cosine(calc_sine_cosine), .calc_value(calc_value)
    );

    function automatic logic [31:0] calc_f(input logic [31:0] th, input logic sc);
        return th ^ (sc ? 32'h0F0F0F0F : 32'h00FF00FF);
    endfunction

    logic [31:0] cpipe [L];
    always @(posedge clk) begin
        cpipe[0] <= calc_enable ? calc_f(calc_theta, calc_sine_cosine) : 32'hDEADBEEF;
        cpipe[1] <= cpipe[0];
    end
    assign calc_value = cpipe[L-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << mon_e.idx));
                chk("rsp_value", 64'(rsp_value), 64'(mon_e.value));
                chk("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end else begin
            chk("rsp_value_quiet", 64'(rsp_value), 64'h0);
        end
    end

    task automatic step(input logic [N-1:0] vld, input logic h,
                        input logic [N-1:0] exp_rdy, input bit push);
        int   wi;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = vld;
        hold      = h;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("calc_enable", 64'(calc_enable), 64'(|exp_rdy));
        if (exp_rdy != '0) begin
            wi = 0;
            for (int i = 0; i < N; i++) if (exp_rdy[i]) wi = i;
            chk("calc_theta", 64'(calc_theta), 64'(req_theta[wi]));
            chk("calc_sc", 64'(calc_sine_cosine), 64'(req_sine_cosine[wi]));
            if (push) begin
                e.idx   = wi;
                e.value = calc_f(req_theta[wi], req_sine_cosine[wi]);
                e.cyc   = cyc + L;
                sb.push_back(e);
            end
        end else begin
            chk("calc_theta_zero", 64'(calc_theta), 64'h0);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_calc_enable", 64'(calc_enable), 64'h0);
        chk("rst_calc_theta", 64'(calc_theta), 64'h0);
        chk("rst_calc_sc", 64'(calc_sine_cosine), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_value", 64'(rsp_value), 64'h0);
        chk("rst_idle", 64'(idle), 64'h1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 4'hF;
        hold      = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        hold            = 1'b0;
        req_valid       = '0;
        req_theta[0]    = 32'h3F800000;
        req_theta[1]    = 32'h40000000;
        req_theta[2]    = 32'h3F000000;
        req_theta[3]    = 32'h40490FDB;
        req_sine_cosine = 4'b0101;

        // Reset with all requests pending: nothing may be granted.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        @(negedge clk);
        check_reset_outputs();
        chk("rst_state", 64'(dut.state_q), 64'(IDLE));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single requester 2: sine select, theta 0.5.
        step(4'b0100, 1'b0, 4'b0100, 1'b1);
        chk("single_theta_const", 64'(calc_theta), 64'h3F000000);
        chk("single_idle_busy", 64'(idle), 64'h0);
        repeat (3) step(4'b0000, 1'b0, 4'b0000, 1'b0);

`ifdef SINCOS_ARB_FIXED_PRIO_EN
        do_reset();
        for (int k = 0; k < 6; k++) step(4'b1010, 1'b0, 4'b0010, 1'b1);
        repeat (3) step(4'b0000, 1'b0, 4'b0000, 1'b0);
`else
        // Round-robin over four continuously valid requesters.
        do_reset();
        for (int k = 0; k < 8; k++) step(4'hF, 1'b0, 4'(4'b0001 << (k % 4)), 1'b1);
        repeat (3) step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("rr_idle_after_drain", 64'(idle), 64'h1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("rr_state_idle", 64'(dut.state_q), 64'(IDLE));

        // Hold with two ops in flight; hold rises together with valid.
        step(4'hF, 1'b0, 4'b0001, 1'b1);
        step(4'hF, 1'b0, 4'b0010, 1'b1);
        step(4'hF, 1'b1, 4'b0000, 1'b0);
        step(4'hF, 1'b1, 4'b0000, 1'b0);
        chk("hold_state_drain", 64'(dut.state_q), 64'(DRAIN));
        chk("hold_not_idle", 64'(idle), 64'h0);
        step(4'hF, 1'b1, 4'b0000, 1'b0);
        chk("hold_idle", 64'(idle), 64'h1);
        step(4'hF, 1'b1, 4'b0000, 1'b0);
        chk("hold_state_idle", 64'(dut.state_q), 64'(IDLE));
        step(4'hF, 1'b0, 4'b0100, 1'b1);

        // Reset one cycle after two grants: their responses must vanish.
        step(4'hF, 1'b0, 4'b1000, 1'b0);
        step(4'hF, 1'b0, 4'b0001, 1'b0);
        do_reset();
        chk("rst_ptr", 64'(dut.ptr_q), 64'h0);
        repeat (4) step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'hF, 1'b0, 4'b0001, 1'b1);
        repeat (3) step(4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

        repeat (2) step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
